// File: rtl/lzc.sv
// -----------------------------------------------------------------------------
// lzc: first-one finder. Reports the index of the lowest set bit of in_i
// (the number of zeros below it) and whether in_i is all zeros.
//
// Ports
//   in_i     in   Width      vector to scan, bit 0 scanned first
//   cnt_o    out  CntWidth   index of the lowest set bit (0 when empty)
//   empty_o  out  1          no bit set in in_i
// -----------------------------------------------------------------------------
module lzc #(
    parameter int unsigned Width    = 8,
    parameter int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        cnt_o = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CntWidth'(i);
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/wrr_pkt_arb_rr_next_sel.sv
// -----------------------------------------------------------------------------
// rr_next_sel: rotating first-one finder. Returns the first set bit of elig_i
// scanning ptr_i+1 .. NumIn-1 and then wrapping to 0 .. ptr_i, so the input at
// ptr_i itself has the lowest priority.
//
// Ports
//   elig_i   in   NumIn      eligible inputs
//   ptr_i    in   IdxWidth   last owner; the scan starts just above it
//   idx_o    out  IdxWidth   selected input (don't care when empty_o)
//   empty_o  out  1          no eligible input
// -----------------------------------------------------------------------------
module rr_next_sel #(
    parameter int unsigned NumIn    = 8,
    parameter int unsigned IdxWidth = $clog2(NumIn)
) (
    input  logic [NumIn-1:0]    elig_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                empty_o
);

    logic [NumIn-1:0]    upper_mask, lower_mask;
    logic [IdxWidth-1:0] upper_idx, lower_idx;
    logic                upper_empty, lower_empty;

    // Upper half holds the indices after the pointer, lower half the wrap.
    for (genvar i = 0; i < NumIn; i++) begin : g_mask
        assign upper_mask[i] = elig_i[i] &  (ptr_i < IdxWidth'(i));
        assign lower_mask[i] = elig_i[i] & ~(ptr_i < IdxWidth'(i));
    end

    lzc #(.Width(NumIn), .CntWidth(IdxWidth)) i_lzc_upper (
        .in_i   (upper_mask),
        .cnt_o  (upper_idx),
        .empty_o(upper_empty)
    );

    lzc #(.Width(NumIn), .CntWidth(IdxWidth)) i_lzc_lower (
        .in_i   (lower_mask),
        .cnt_o  (lower_idx),
        .empty_o(lower_empty)
    );

    assign idx_o   = upper_empty ? lower_idx : upper_idx;
    assign empty_o = upper_empty & lower_empty;

endmodule

// File: rtl/wrr_pkt_arb.sv
// -----------------------------------------------------------------------------
// wrr_pkt_arb: weighted round-robin, packet-atomic N:1 arbiter for multi-beat
// valid/ready streams. Each input owns the output for a turn of up to
// weight_i[i] packets; a granted packet keeps the output until its last beat.
// Weight 0 disables an input. All outputs are combinational from the inputs
// and the arbiter state.
//
// Ports
//   clk_i     in   1                   clock, rising edge
//   rst_ni    in   1                   asynchronous reset, active low
//   flush_i   in   1                   synchronous clear of all arbiter state
//   weight_i  in   NumIn*WeightWidth   per-input weight (packets per turn)
//   req_i     in   NumIn               per-input beat valid
//   last_i    in   NumIn               per-input last beat of packet
//   data_i    in   NumIn*DataWidth     per-input beat payload
//   gnt_o     out  NumIn               per-input ready, onehot0
//   req_o     out  1                   output valid
//   gnt_i     in   1                   output ready
//   data_o    out  DataWidth           selected payload
//   last_o    out  1                   selected last flag
//   idx_o     out  IdxWidth            selected input index
// -----------------------------------------------------------------------------
module wrr_pkt_arb #(
    parameter int unsigned NumIn       = 8,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]             req_i,
    input  logic [NumIn-1:0]             last_i,
    input  logic [NumIn*DataWidth-1:0]   data_i,
    output logic [NumIn-1:0]             gnt_o,
    output logic                         req_o,
    input  logic                         gnt_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         last_o,
    output logic [IdxWidth-1:0]          idx_o
);

    logic [WeightWidth-1:0] weight [NumIn];
    logic [DataWidth-1:0]   data   [NumIn];
    logic [NumIn-1:0]       elig;

    logic [IdxWidth-1:0]    owner_q, owner_d, sel_q, sel_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic                   locked_q, locked_d, hold_q, hold_d;
    // Set once the first turn has started. Until then the rotation starts at
    // input 0, which gives input 0 top priority out of reset and flush.
    logic                   turn_q, turn_d;

    logic [IdxWidth-1:0]    sel, rr_ptr, rr_idx;
    logic                   rr_empty, xfer;

    for (genvar i = 0; i < NumIn; i++) begin : g_unpack
        assign weight[i] = weight_i[i*WeightWidth +: WeightWidth];
        assign data[i]   = data_i[i*DataWidth +: DataWidth];
        assign elig[i]   = req_i[i] & (weight[i] != '0);
    end

    assign rr_ptr = turn_q ? owner_q : IdxWidth'(NumIn - 1);

    rr_next_sel #(.NumIn(NumIn), .IdxWidth(IdxWidth)) i_rr_next_sel (
        .elig_i (elig),
        .ptr_i  (rr_ptr),
        .idx_o  (rr_idx),
        .empty_o(rr_empty)
    );

    // Selection. A locked packet or a stalled offer ignores the eligible set
    // so the owner finishes its packet even if its weight drops to 0, and an
    // offered beat stays stable until it transfers.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel   = rr_idx;
        req_o = ~rr_empty;
        if (locked_q) begin
            sel   = owner_q;
            req_o = req_i[owner_q];
        end else if (hold_q) begin
            sel   = sel_q;
            req_o = req_i[sel_q];
        end else if (elig[owner_q] && credit_q != '0) begin
            sel   = owner_q;
            req_o = 1'b1;
        end
    end

    assign xfer   = req_o & gnt_i;
    assign idx_o  = sel;
    assign data_o = data[sel];
    assign last_o = last_i[sel];
    assign gnt_o  = xfer ? ({{(NumIn-1){1'b0}}, 1'b1} << sel) : '0;

    always_comb begin
        owner_d  = owner_q;
        credit_d = credit_q;
        locked_d = locked_q;
        hold_d   = hold_q;
        turn_d   = turn_q;
        sel_d    = sel;
        if (flush_i) begin
            owner_d  = '0;
            credit_d = '0;
            locked_d = 1'b0;
            hold_d   = 1'b0;
            turn_d   = 1'b0;
            sel_d    = '0;
        end else if (xfer) begin
            // Turn accounting happens on the first beat of a packet only.
            if (!locked_q) begin
                if (sel == owner_q && credit_q != '0) begin
                    credit_d = credit_q - WeightWidth'(1);
                end else begin
                    owner_d  = sel;
                    turn_d   = 1'b1;
                    credit_d = (weight[sel] == '0) ? '0 : weight[sel] - WeightWidth'(1);
                end
            end
            locked_d = ~last_i[sel];
            hold_d   = 1'b0;
        end else begin
            hold_d = req_o & ~locked_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            credit_q <= '0;
            locked_q <= 1'b0;
            hold_q   <= 1'b0;
            turn_q   <= 1'b0;
            sel_q    <= '0;
        end else begin
            owner_q  <= owner_d;
            credit_q <= credit_d;
            locked_q <= locked_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            sel_q    <= sel_d;
        end
    end

endmodule

// File: tb/tb_wrr_pkt_arb.sv
// -----------------------------------------------------------------------------
// tb_wrr_pkt_arb: self-checking bench for wrr_pkt_arb (8 inputs, 32-bit data,
// 4-bit weights). Directed scenarios use fixed expected sequences; the random
// scenario compares against a packet-level reference model of the arbitration
// rules. Inputs change just after the falling edge, outputs are sampled 1 ns
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_wrr_pkt_arb;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush = 1'b0;
    logic [N*WW-1:0] weight_bus;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    last = '0;
    logic [N*DW-1:0] data_bus;
    logic [N-1:0]    gnt_o;
    logic            req_o;
    logic            gnt = 1'b0;
    logic [DW-1:0]   data_o;
    logic            last_o;
    logic [2:0]      idx_o;

    logic [WW-1:0]   lane_w    [N];
    logic [DW-1:0]   lane_data [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: current turn owner, packets left in the turn,
    // mid-packet flag, stalled offer and whether any turn has started yet.
    int m_owner, m_credit, m_sel;
    bit m_locked, m_hold, m_started;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            weight_bus[i*WW +: WW] = lane_w[i];
            data_bus[i*DW +: DW]   = lane_data[i];
        end
    end

    wrr_pkt_arb #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .weight_i(weight_bus),
        .req_i   (req),
        .last_i  (last),
        .data_i  (data_bus),
        .gnt_o   (gnt_o),
        .req_o   (req_o),
        .gnt_i   (gnt),
        .data_o  (data_o),
        .last_o  (last_o),
        .idx_o   (idx_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic set_weights(input logic [WW-1:0] w);
        for (int i = 0; i < N; i++) lane_w[i] = w;
    endtask

    task automatic set_lane_tags();
        for (int i = 0; i < N; i++) lane_data[i] = 32'hA000_0000 | DW'(i);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        flush  = 1'b0;
        req    = '0;
        last   = '0;
        gnt    = 1'b0;
        set_weights(4'd1);
        set_lane_tags();
        m_owner = 0; m_credit = 0; m_sel = 0;
        m_locked = 0; m_hold = 0; m_started = 0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    function automatic bit elig(int i);
        return req[i] && lane_w[i] != '0;
    endfunction

    task automatic model_select(output bit r, output int s);
        int start;
        r = 0;
        s = 0;
        if (m_locked) begin
            s = m_owner;
            r = req[m_owner];
        end else if (m_hold) begin
            s = m_sel;
            r = req[m_sel];
        end else if (elig(m_owner) && m_credit > 0) begin
            s = m_owner;
            r = 1;
        end else begin
            start = m_started ? (m_owner + 1) % N : 0;
            for (int k = 0; k < N; k++) begin
                if (!r && elig((start + k) % N)) begin
                    s = (start + k) % N;
                    r = 1;
                end
            end
        end
    endtask

    task automatic model_update(input bit r, input int s);
        if (flush) begin
            m_owner = 0; m_credit = 0; m_sel = 0;
            m_locked = 0; m_hold = 0; m_started = 0;
        end else if (r && gnt) begin
            if (!m_locked) begin
                if (s == m_owner && m_credit > 0) begin
                    m_credit--;
                end else begin
                    m_owner   = s;
                    m_credit  = (lane_w[s] == 0) ? 0 : int'(lane_w[s]) - 1;
                    m_started = 1;
                end
            end
            m_locked = !last[s];
            m_hold   = 0;
        end else begin
            m_hold = r && !m_locked;
            m_sel  = s;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if (req_o !== 1'b0 || gnt_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle: req_o=%b gnt_o=%h, required req_o=0 gnt_o=00", req_o, gnt_o);
        end
        @(negedge clk);
        req = 8'hFF;
        #1;
        n_tests++;
        if (req_o !== 1'b1 || idx_o !== 3'd0 || gnt_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_first: req_o=%b idx_o=%0d gnt_o=%h, required 1/0/00", req_o, idx_o, gnt_o);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req  = 8'hFF;
        last = 8'hFF;
        gnt  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_tests++;
            if (idx_o !== 3'(k % N) || gnt_o !== (8'h01 << (k % N)) ||
                data_o !== (32'hA000_0000 | 32'(k % N))) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: idx_o=%0d gnt_o=%h data_o=%h, required idx %0d", k, idx_o, gnt_o,
                         data_o, k % N);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_weighted();
        int exp_seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        apply_reset();
        lane_w[0] = 4'd3;
        lane_w[1] = 4'd1;
        req  = 8'h03;
        last = 8'hFF;
        gnt  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_tests++;
            if (idx_o !== 3'(exp_seq[k]) || req_o !== 1'b1) begin
                n_fail++;
                $display("FAIL weighted_%0d: idx_o=%0d req_o=%b, required idx %0d", k, idx_o, req_o, exp_seq[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_packet_lock();
        int exp_idx[7]  = '{0, 1, 2, 2, 2, 2, 3};
        bit exp_last[7] = '{1, 1, 0, 0, 0, 1, 1};
        apply_reset();
        req  = 8'hFF;
        last = 8'hFF;
        gnt  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            last[2] = (k >= 5);
            #1;
            n_tests++;
            if (idx_o !== 3'(exp_idx[k]) || last_o !== exp_last[k]) begin
                n_fail++;
                $display("FAIL lock_%0d: idx_o=%0d last_o=%b, required %0d/%b", k, idx_o, last_o, exp_idx[k],
                         exp_last[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req  = 8'h30;
        last = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            gnt = (k == 3);
            if (k == 1) req[0] = 1'b1;  // higher priority arrival must not disturb the offer
            #1;
            n_tests++;
            if (idx_o !== 3'd4 || req_o !== 1'b1 || gnt_o !== ((k == 3) ? 8'h10 : 8'h00)) begin
                n_fail++;
                $display("FAIL hold_%0d: idx_o=%0d req_o=%b gnt_o=%h, required idx 4", k, idx_o, req_o, gnt_o);
            end
            @(negedge clk);
        end
        req[4] = 1'b0;
        #1;
        n_tests++;
        if (idx_o !== 3'd5 || gnt_o !== 8'h20) begin
            n_fail++;
            $display("FAIL hold_after: idx_o=%0d gnt_o=%h, required 5/20", idx_o, gnt_o);
        end
    endtask

    task automatic test_disable_flush();
        apply_reset();
        lane_w[1] = 4'd0;
        req  = 8'h02;
        gnt  = 1'b1;
        #1;
        n_tests++;
        if (req_o !== 1'b0 || gnt_o !== 8'h00) begin
            n_fail++;
            $display("FAIL disabled: req_o=%b gnt_o=%h, required 0/00", req_o, gnt_o);
        end
        @(negedge clk);
        req  = 8'h20;
        last = 8'h00;
        #1;
        n_tests++;
        if (idx_o !== 3'd5 || gnt_o !== 8'h20) begin
            n_fail++;
            $display("FAIL pkt5_first: idx_o=%0d gnt_o=%h, required 5/20", idx_o, gnt_o);
        end
        @(negedge clk);
        req   = 8'hFF;
        flush = 1'b1;
        #1;
        n_tests++;
        if (idx_o !== 3'd5) begin
            n_fail++;
            $display("FAIL pkt5_locked: idx_o=%0d, required 5", idx_o);
        end
        @(negedge clk);
        flush = 1'b0;
        last  = 8'hFF;
        #1;
        n_tests++;
        if (idx_o !== 3'd0 || req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL after_flush: idx_o=%0d req_o=%b, required 0/1", idx_o, req_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_weights(4'd3);
        req  = 8'hFF;
        last = 8'hFF;
        gnt  = 1'b1;
        #1;
        n_tests++;
        if (idx_o !== 3'd0) begin
            n_fail++;
            $display("FAIL ar_first: idx_o=%0d, required 0", idx_o);
        end
        @(negedge clk);
        req = 8'hFE;
        #1;
        n_tests++;
        if (idx_o !== 3'd1) begin
            n_fail++;
            $display("FAIL ar_owner1: idx_o=%0d, required 1", idx_o);
        end
        @(negedge clk);
        req = 8'hFF;
        gnt = 1'b0;
        #1;
        n_tests++;
        if (idx_o !== 3'd1) begin
            n_fail++;
            $display("FAIL ar_midturn: idx_o=%0d, required 1", idx_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (idx_o !== 3'd0 || req_o !== 1'b1 || gnt_o !== 8'h00) begin
            n_fail++;
            $display("FAIL ar_in_reset: idx_o=%0d req_o=%b gnt_o=%h, required 0/1/00", idx_o, req_o, gnt_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        gnt    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (idx_o !== 3'd0 || gnt_o !== 8'h01) begin
                n_fail++;
                $display("FAIL ar_release_%0d: idx_o=%0d gnt_o=%h, required 0/01", k, idx_o, gnt_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int beats[N];
        bit exp_r, did_xfer;
        int exp_s, w_idx;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            lane_w[i] = WW'($urandom_range(1, 3));
            beats[i]  = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (beats[i] == 0 && $urandom_range(0, 1) == 1) begin
                    beats[i]     = $urandom_range(1, 4);
                    req[i]       = 1'b1;
                    lane_data[i] = $urandom;
                    last[i]      = (beats[i] == 1);
                end
            end
            if (!m_hold && $urandom_range(0, 15) == 0) begin
                w_idx         = $urandom_range(0, N - 1);
                lane_w[w_idx] = WW'($urandom_range(0, 3));
            end
            flush = ($urandom_range(0, 63) == 0);
            gnt   = ($urandom_range(0, 3) != 0);
            #1;
            model_select(exp_r, exp_s);
            n_tests++;
            if (exp_r) begin
                if (req_o !== 1'b1 || idx_o !== 3'(exp_s) || data_o !== lane_data[exp_s] ||
                    last_o !== last[exp_s] || gnt_o !== (gnt ? (8'h01 << exp_s) : 8'h00)) begin
                    n_fail++;
                    $display("FAIL random_c%0d: req_o=%b idx_o=%0d gnt_o=%h last_o=%b, required 1/%0d/%h/%b", cyc,
                             req_o, idx_o, gnt_o, last_o, exp_s, gnt ? (8'h01 << exp_s) : 8'h00, last[exp_s]);
                end
            end else if (req_o !== 1'b0 || gnt_o !== 8'h00) begin
                n_fail++;
                $display("FAIL random_c%0d: req_o=%b gnt_o=%h, required 0/00", cyc, req_o, gnt_o);
            end
            did_xfer = exp_r && gnt;
            model_update(exp_r, exp_s);
            @(negedge clk);
            if (did_xfer) begin
                beats[exp_s]--;
                if (beats[exp_s] == 0) begin
                    req[exp_s]  = 1'b0;
                    last[exp_s] = 1'b0;
                end else begin
                    lane_data[exp_s] = $urandom;
                    last[exp_s]      = (beats[exp_s] == 1);
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        set_weights(4'd1);
        set_lane_tags();
        test_reset();
        test_round_robin();
        test_weighted();
        test_packet_lock();
        test_backpressure();
        test_disable_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
